// File: rtl/serial_adder.sv
// Digit-serial two's-complement adder/subtractor, DIGIT bits per clock, LSB digit first.
// Latency: Done pulses N = WIDTH/DIGIT edges after the accepting edge (N+1 edges counting that edge).
// Backpressure: Start is ignored while Busy; Start is accepted in IDLE or in the Done cycle.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  // Operands are shifted right one digit per BUSY edge so digit 0 is always the live one.
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  // Partial sum fills in from the top; after N digits it holds the full result.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] a_dig, b_dig, s_dig;
  logic             c_out;
  logic             last;
  logic [WIDTH-1:0] acc_shift;

  assign a_dig = a_q[DIGIT-1:0];
  assign b_dig = b_q[DIGIT-1:0];
  assign {c_out, s_dig} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, c_q};
  assign last      = (cnt_q == CW'(N - 1));
  assign acc_shift = (acc_q >> DIGIT) | (WIDTH'(s_dig) << (WIDTH - DIGIT));

  // Next-state and datapath update: capture on accepted Start, one digit per BUSY cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    c_d     = c_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d = BUSY;
          a_d     = A;
          // Subtraction is A + ~B + 1: invert B once here and seed the carry with 1.
          b_d     = Mode ? ~B : B;
          c_d     = Mode ? 1'b1 : Cin;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        c_d   = c_out;
        acc_d = acc_shift;
        if (last) begin
          // Counter holds here rather than wrapping; it is cleared on the next capture.
          state_d = DONE;
          sum_d   = acc_shift;
          carry_d = c_out;
          // Same-sign operands producing a different-sign result is exactly
          // carry-into-MSB XOR carry-out-of-MSB (B here is already inverted for subtract).
          ovf_d   = (a_dig[DIGIT-1] == b_dig[DIGIT-1]) && (s_dig[DIGIT-1] != a_dig[DIGIT-1]);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset taking priority over Start.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Busy     = (state_q == BUSY);
  assign Done     = (state_q == DONE);
  assign Sum      = sum_q;
  assign Carry    = carry_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder (WIDTH=16, DIGIT=4): directed cases plus random operations
// checked against an arithmetic reference model.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_serial_adder;

  logic        Clk = 1'b0;
  logic        Rst, Start, Mode, Cin;
  logic [15:0] A, B;
  logic        Busy, Done, Carry, Overflow;
  logic [15:0] Sum;

  int checks   = 0;
  int failures = 0;

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Mode(Mode), .A(A), .B(B), .Cin(Cin),
    .Busy(Busy), .Done(Done), .Sum(Sum), .Carry(Carry), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {carry, overflow, sum} from plain integer arithmetic.
  function automatic logic [17:0] ref_model(input logic mode, input logic [15:0] a,
                                            input logic [15:0] b, input logic cin);
    int unsigned u;
    int          s;
    logic        cy, ov;
    if (mode) begin
      u  = 32'(a) + 32'(16'(~b)) + 1;
      s  = int'($signed(a)) - int'($signed(b));
    end else begin
      u  = 32'(a) + 32'(b) + 32'(cin);
      s  = int'($signed(a)) + int'($signed(b)) + int'(cin);
    end
    cy = (u > 32'hFFFF);
    ov = (s > 32767) || (s < -32768);
    return {cy, ov, u[15:0]};
  endfunction

  // Present an operation and let the next edge accept it.
  task automatic start_op(input logic mode, input logic [15:0] a, input logic [15:0] b,
                          input logic cin);
    Mode = mode; A = a; B = b; Cin = cin; Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // Called just after the accepting edge. Follows the operation to its Done cycle and
  // returns there. Latency counts the accepting edge as edge 1, so Done is expected
  // after edge 5 (N+1). Optionally pokes a different Start mid-operation.
  task automatic wait_done(input string tag, input logic [17:0] exp,
                           input logic [15:0] prev_sum, input bit poke);
    int   busy_cnt = 0;
    int   lat      = 1;
    bit   seen     = 0;
    bit   held     = 1;
    for (int k = 0; k < 20; k++) begin
      if (Done) begin
        seen = 1;
        break;
      end
      if (Busy) busy_cnt++;
      if (Sum !== prev_sum) held = 0;
      if (poke && busy_cnt == 2) begin
        Start = 1'b1; A = 16'($urandom); B = 16'($urandom); Mode = ~Mode; Cin = ~Cin;
      end
      tick();
      Start = 1'b0;
      lat++;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"},   32'(lat), 32'd5);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
    chk({tag, "_sum_held"},  32'(held), 32'd1);
    chk({tag, "_sum"},       32'(Sum), 32'(exp[15:0]));
    chk({tag, "_carry"},     32'(Carry), 32'(exp[17]));
    chk({tag, "_ovf"},       32'(Overflow), 32'(exp[16]));
  endtask

  initial begin
    logic [17:0] exp;
    logic [15:0] prev;
    logic [15:0] ra, rb;
    logic        rm, rc;
    int          done_cnt;

    Rst = 1'b1; Start = 1'b0; Mode = 1'b0; Cin = 1'b0; A = '0; B = '0;
    tick(); tick();
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_sum",  32'(Sum), 32'd0);
    chk("rst_flags", 32'({Carry, Overflow}), 32'd0);
    Rst = 1'b0;
    tick();
    chk("idle_stays", 32'({Busy, Done}), 32'd0);

    // Directed arithmetic cases with hand-derived results.
    start_op(1'b0, 16'h1234, 16'h0FFF, 1'b1);
    wait_done("add_basic", {1'b0, 1'b0, 16'h2234}, 16'h0000, 0);
    tick();
    chk("done_one_cycle", 32'({Busy, Done}), 32'd0);

    start_op(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    wait_done("add_wrap", {1'b1, 1'b0, 16'h0000}, 16'h2234, 0);
    tick();

    start_op(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    wait_done("add_ovf", {1'b0, 1'b1, 16'h8000}, 16'h0000, 0);
    tick();

    start_op(1'b1, 16'h0005, 16'h0007, 1'b1);
    wait_done("sub_borrow", {1'b0, 1'b0, 16'hFFFE}, 16'h8000, 0);
    tick();

    // Start during BUSY is ignored; Start held in DONE runs back-to-back.
    start_op(1'b0, 16'h1234, 16'h0FFF, 1'b1);
    wait_done("busy_poke", {1'b0, 1'b0, 16'h2234}, 16'hFFFE, 1);
    start_op(1'b1, 16'h8000, 16'h0001, 1'b0);
    wait_done("b2b", {1'b1, 1'b1, 16'h7FFF}, 16'h2234, 0);
    tick();

    // Reset during the 2nd BUSY cycle abandons the operation.
    start_op(1'b0, 16'h00FF, 16'h0F0F, 1'b0);
    tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_done", 32'(Done), 32'd0);
    chk("midrst_sum",  32'(Sum), 32'd0);
    chk("midrst_flags", 32'({Carry, Overflow}), 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (Done) done_cnt++;
      tick();
    end
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    start_op(1'b0, 16'h0001, 16'h0002, 1'b0);
    wait_done("after_rst", {1'b0, 1'b0, 16'h0003}, 16'h0000, 0);
    prev = 16'h0003;

    // Random operations, some back-to-back, some with an idle gap.
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rm = 1'($urandom); rc = 1'($urandom);
      if (i % 6 == 0) rb = 16'hFFFF - ra;
      if ($urandom_range(0, 1) == 0) begin
        tick();
        chk("rand_idle", 32'({Busy, Done}), 32'd0);
      end
      exp = ref_model(rm, ra, rb, rc);
      start_op(rm, ra, rb, rc);
      wait_done("rand", exp, prev, (i % 5 == 2));
      prev = exp[15:0];
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
